axi_lite_rr_arbiter: RTL
========================

Name: axi_lite_rr_arbiter

Overview:
Two-requester round-robin arbiter that shares one AXI-Lite master command port (WRITE/READ/ADDR/W_DATA/R_DATA/DONE/RW_STATUS).
Each requester presents a level request and holds it until acknowledged. The arbiter issues a single-cycle command pulse to the master, tracks the transaction through completion, and returns read data and response status to the granted requester.
It sits between CPU-side/DMA-side register clients and the AXI-Lite master.

Parameters:
AW, 32, address width
DW, 32, data width
TO_CYC, 256, watchdog limit in cycles (used only with the optional feature); must be ≥2

Ports:
CLK  in  1  clock, rising edge
RESETn  in  1  asynchronous active-low reset
REQ0_WR  in  1  requester 0 write request, level, held until REQ0_ACK
REQ0_RD  in  1  requester 0 read request, level, held until REQ0_ACK
REQ0_ADDR  in  AW  requester 0 address, stable while request held
REQ0_WDATA  in  DW  requester 0 write data
REQ0_ACK  out  1  one-cycle completion pulse to requester 0
REQ0_RDATA  out  DW  read data, valid in REQ0_ACK cycle
REQ0_STATUS  out  2  xRESP code, valid in REQ0_ACK cycle
REQ1_WR, REQ1_RD, REQ1_ADDR, REQ1_WDATA, REQ1_ACK, REQ1_RDATA, REQ1_STATUS  same widths and directions, requester 1
M_WRITE  out  1  one-cycle write command pulse to master
M_READ  out  1  one-cycle read command pulse to master
M_ADDR  out  AW  command address
M_WDATA  out  DW  command write data
M_RDATA  in  DW  master read data, valid in the cycle M_DONE returns high
M_DONE  in  1  master idle flag: high when idle, low while a transaction is in flight
M_STATUS  in  2  master response status
GRANT  out  2  one-hot current owner; 00 when idle
BUSY  out  1  high in any state other than IDLE

Behaviour:
- States:
  - IDLE: no transaction in progress.
  - ISSUE: command pulse cycle.
  - WAIT_BUSY: waiting for M_DONE to fall.
  - WAIT_DONE: waiting for M_DONE to rise.
  - RESP: acknowledge cycle.
- IDLE -> ISSUE when any request is present.
  - Only one requester active: it wins.
  - Both active: the requester not served last wins. The last_grant register resets to 1, so requester 0 wins the first tie.
  - Winner latches ADDR, WDATA and op into M_ADDR/M_WDATA/op registers; GRANT is set.
- Same requester asserts both WR and RD: write is performed; RD is ignored for that grant.
- ISSUE (1 cycle):
  - M_WRITE or M_READ = 1 for exactly this cycle.
  - M_ADDR/M_WDATA are stable from ISSUE through RESP.
  - Next state is WAIT_BUSY.
- WAIT_BUSY: M_DONE=0 -> WAIT_DONE; otherwise stay.
- WAIT_DONE: M_DONE=1 -> RESP; M_RDATA and M_STATUS are captured on this edge.
- RESP (1 cycle):
  - Granted REQn_ACK = 1; REQn_RDATA/STATUS driven from the captured registers.
  - last_grant <= owner.
  - Next state is IDLE; GRANT returns to 00.
- Requesters drop their request on the cycle after ACK. A request still high in the IDLE cycle following RESP is treated as a new request.
- Minimum turnaround: ISSUE to ACK is 4 cycles when the master drops DONE the cycle after the pulse.
- A request deasserted before grant is simply lost (no ACK). A request deasserted after grant does not abort the transaction; ACK is still pulsed.
- Non-granted requester outputs: ACK=0; RDATA/STATUS hold their last values.
- Reset (asynchronous, any state):
  - State -> IDLE; M_WRITE=M_READ=0; GRANT=00; BUSY=0; ACKs=0.
  - M_ADDR, M_WDATA, RDATA and STATUS registers = 0; last_grant=1.
- The arbiter accepts only one outstanding transaction; no pipelining.

Optional Feature:
- Macro: AXI_ARB_WATCHDOG_EN.
- Defined:
  - A counter runs during WAIT_BUSY and WAIT_DONE and clears in every other state.
  - On reaching TO_CYC-1, the FSM goes to RESP with captured STATUS forced to 2'b10 (SLVERR) and RDATA forced to 0.
  - A sticky output TIMEOUT (1 bit) is set; it clears only on reset.
- Undefined: no counter, no TIMEOUT port; the arbiter waits indefinitely.

Decomposition:
- Package axi_lite_pkg:
  - state encoding constants (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP, 3 bits)
  - xRESP constants (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11)
  - default AW/DW
- One sub-module: rr_pick2, a combinational two-input round-robin picker (requests and last_grant in, one-hot winner out).

Test Plan:
- Single write: REQ0_WR with ADDR=0x0000_0010, WDATA=0xDEAD_BEEF; master drops DONE 1 cycle after the pulse and raises it 3 cycles later with STATUS=00 -> exactly one M_WRITE pulse carrying that addr/data; REQ0_ACK one cycle; REQ0_STATUS=00; GRANT=01 throughout.
- Read return: REQ1_RD with ADDR=0x24; master returns M_RDATA=0x1234_5678, STATUS=00 -> REQ1_RDATA=0x1234_5678 in the ACK cycle; M_WRITE is never asserted.
- Contention: REQ0_WR and REQ1_RD both asserted from reset and held until their ACKs -> service order is 0, 1, 0, 1 across four transactions; no back-to-back grants to the same requester.
- WR and RD both high on requester 0 -> one M_WRITE pulse, no M_READ, single ACK.
- Error response: master returns STATUS=2'b11 -> REQ0_STATUS=11 in the ACK cycle; the next transaction proceeds normally.
- Reset mid-operation: assert RESETn=0 in WAIT_DONE -> BUSY=0, GRANT=00, no ACK; after release, a held request is reissued as a new ISSUE. With AXI_ARB_WATCHDOG_EN and M_DONE held high forever, ACK arrives after TO_CYC cycles with STATUS=10 and TIMEOUT=1.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI-Lite command-port arbiter: FSM state encoding,
// xRESP codes and default bus widths.
package axi_lite_pkg;

  localparam int AXI_AW_DEF = 32;
  localparam int AXI_DW_DEF = 32;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } arb_state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker; zero latency, no backpressure.
// On a tie the requester that was not served last wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = last_grant ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/axi_lite_rr_arbiter.sv
// Two-requester round-robin front end for one AXI-Lite master; ISSUE to ACK >= 4 cycles, one transaction
// outstanding, requests are held off (level, no ACK) while busy. AXI_ARB_WATCHDOG_EN adds a timeout + TIMEOUT.
module axi_lite_rr_arbiter
  import axi_lite_pkg::*;
#(
  parameter int AW     = AXI_AW_DEF,
  parameter int DW     = AXI_DW_DEF,
  parameter int TO_CYC = 256
) (
  input  logic          CLK,
  input  logic          RESETn,
  input  logic          REQ0_WR,
  input  logic          REQ0_RD,
  input  logic [AW-1:0] REQ0_ADDR,
  input  logic [DW-1:0] REQ0_WDATA,
  output logic          REQ0_ACK,
  output logic [DW-1:0] REQ0_RDATA,
  output logic [1:0]    REQ0_STATUS,
  input  logic          REQ1_WR,
  input  logic          REQ1_RD,
  input  logic [AW-1:0] REQ1_ADDR,
  input  logic [DW-1:0] REQ1_WDATA,
  output logic          REQ1_ACK,
  output logic [DW-1:0] REQ1_RDATA,
  output logic [1:0]    REQ1_STATUS,
  output logic          M_WRITE,
  output logic          M_READ,
  output logic [AW-1:0] M_ADDR,
  output logic [DW-1:0] M_WDATA,
  input  logic [DW-1:0] M_RDATA,
  input  logic          M_DONE,
  input  logic [1:0]    M_STATUS,
  output logic [1:0]    GRANT,
  output logic          BUSY
`ifdef AXI_ARB_WATCHDOG_EN
  ,
  output logic          TIMEOUT
`endif
);

  arb_state_t    state_q, state_d;
  logic          owner_q;
  logic          op_wr_q;
  logic          last_grant_q;
  logic [AW-1:0] m_addr_q;
  logic [DW-1:0] m_wdata_q;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic [1:0]    status0_q, status1_q;

  logic [1:0]    req;
  logic [1:0]    win;
  logic          win_is1;
  logic          done_ok;
  logic          wd_expire;
  logic          wd_to;

  assign req     = {REQ1_WR | REQ1_RD, REQ0_WR | REQ0_RD};
  assign win_is1 = (win == 2'b10);

  rr_pick2 u_pick (
    .req        (req),
    .last_grant (last_grant_q),
    .win        (win)
  );

  // A real completion in the same cycle as the watchdog expiry keeps its data.
  assign done_ok = (state_q == WAIT_DONE) && M_DONE;
  assign wd_to   = wd_expire && !done_ok;

`ifdef AXI_ARB_WATCHDOG_EN
  localparam int             WD_W    = $clog2(TO_CYC);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TO_CYC - 1);

  logic            in_wait;
  logic [WD_W-1:0] wd_cnt_q;
  logic            timeout_q;

  assign in_wait   = (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);
  assign wd_expire = in_wait && (wd_cnt_q == WD_LAST);
  assign TIMEOUT   = timeout_q;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q <= in_wait ? wd_cnt_q + 1'b1 : '0;
      if (wd_to) timeout_q <= 1'b1;
    end
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (|req) state_d = ISSUE;
      ISSUE:     state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (wd_to)        state_d = RESP;
        else if (!M_DONE) state_d = WAIT_DONE;
      end
      WAIT_DONE: if (done_ok || wd_to) state_d = RESP;
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      op_wr_q      <= 1'b0;
      last_grant_q <= 1'b1;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      status0_q    <= OKAY;
      status1_q    <= OKAY;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && |req) begin
        owner_q   <= win_is1;
        op_wr_q   <= win_is1 ? REQ1_WR    : REQ0_WR;
        m_addr_q  <= win_is1 ? REQ1_ADDR  : REQ0_ADDR;
        m_wdata_q <= win_is1 ? REQ1_WDATA : REQ0_WDATA;
      end
      // Per-requester result registers so the idle requester keeps its last result.
      if (done_ok || wd_to) begin
        if (owner_q) begin
          rdata1_q  <= done_ok ? M_RDATA  : '0;
          status1_q <= done_ok ? M_STATUS : SLVERR;
        end else begin
          rdata0_q  <= done_ok ? M_RDATA  : '0;
          status0_q <= done_ok ? M_STATUS : SLVERR;
        end
      end
      if (state_q == RESP) last_grant_q <= owner_q;
    end
  end

  assign M_WRITE     = (state_q == ISSUE) &&  op_wr_q;
  assign M_READ      = (state_q == ISSUE) && !op_wr_q;
  assign M_ADDR      = m_addr_q;
  assign M_WDATA     = m_wdata_q;
  assign REQ0_ACK    = (state_q == RESP) && !owner_q;
  assign REQ1_ACK    = (state_q == RESP) &&  owner_q;
  assign REQ0_RDATA  = rdata0_q;
  assign REQ1_RDATA  = rdata1_q;
  assign REQ0_STATUS = status0_q;
  assign REQ1_STATUS = status1_q;
  assign GRANT       = (state_q == IDLE) ? 2'b00 : onehot2(owner_q);
  assign BUSY        = (state_q != IDLE);

endmodule
